// File: rtl/text_terminal_if.sv
// rtl/text_terminal_if.sv - byte input, video read port and cursor signals of text_terminal
interface text_terminal_if #(
    parameter int CW = 7,
    parameter int RW = 5
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] rd_col;
    logic [RW-1:0] rd_row;
    logic [7:0]    rd_data;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          busy;

    modport master (
        output in_data, in_valid, rd_col, rd_row,
        input  in_ready, rd_data, cur_col, cur_row, busy
    );

    modport slave (
        input  in_data, in_valid, rd_col, rd_row,
        output in_ready, rd_data, cur_col, cur_row, busy
    );
endinterface

// File: rtl/text_terminal.sv
// rtl/text_terminal.sv - character-cell terminal: byte stream in, COLS x ROWS buffer with cursor,
// pointer-rotation scrolling and a registered video read port
module text_terminal #(
    parameter int COLS = 80,
    parameter int ROWS = 30,
    parameter int TAB  = 8
) (
    input  logic           clk,
    input  logic           reset,
    text_terminal_if.slave term
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);

    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [RW-1:0] top_q, top_d;
    logic [RW-1:0] clr_row_q, clr_row_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [7:0]    mem [CELLS];
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          accept;
    logic          newline;
    logic          rd_oob;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data_q;

    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] top, input logic [RW-1:0] row);
        int sum;
        sum = int'(top) + int'(row);
        if (sum >= ROWS) sum = sum - ROWS;
        return RW'(sum);
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow, input logic [CW-1:0] col);
        return AW'(int'(prow) * COLS + int'(col));
    endfunction

    function automatic logic [CW-1:0] tab_stop(input logic [CW-1:0] col);
        int stop;
        stop = (int'(col) & ~(TAB - 1)) + TAB;
        if (stop > COLS - 1) stop = COLS - 1;
        return CW'(stop);
    endfunction

    assign term.in_ready = (state_q == IDLE) && !reset;
    assign term.busy     = !term.in_ready;
    assign term.cur_col  = col_q;
    assign term.cur_row  = row_q;
    assign term.rd_data  = rd_data_q;
    assign accept        = term.in_valid && term.in_ready;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        top_d     = top_q;
        clr_row_d = clr_row_q;
        cnt_d     = cnt_q;
        we        = 1'b0;
        waddr     = cell_addr(phys_row(top_q, row_q), col_q);
        wdata     = term.in_data;
        newline   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (term.in_data >= 8'h20 && term.in_data <= 8'h7E) begin
                        we = 1'b1;
                        if (col_q == CW'(COLS - 1)) begin
                            col_d   = '0;
                            newline = 1'b1;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        case (term.in_data)
                            8'h0D: col_d = '0;
                            8'h0A: newline = 1'b1;
                            8'h08: if (col_q != '0) col_d = col_q - CW'(1);
                            8'h09: col_d = tab_stop(col_q);
                            8'h0C: begin
                                state_d = CLR_ALL;
                                cnt_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                    // Scrolling only moves the top pointer; the old top row becomes the blank bottom row
                    if (newline) begin
                        if (row_q != RW'(ROWS - 1)) begin
                            row_d = row_q + RW'(1);
                        end else begin
                            top_d     = (top_q == RW'(ROWS - 1)) ? '0 : top_q + RW'(1);
                            clr_row_d = top_q;
                            cnt_d     = '0;
                            state_d   = CLR_LINE;
                        end
                    end
                end
            end
            CLR_LINE: begin
                we    = 1'b1;
                wdata = 8'h20;
                waddr = cell_addr(clr_row_q, CW'(cnt_q));
                if (cnt_q == AW'(COLS - 1)) state_d = IDLE;
                else cnt_d = cnt_q + AW'(1);
            end
            CLR_ALL: begin
                we    = 1'b1;
                wdata = 8'h20;
                waddr = cnt_q;
                if (cnt_q == AW'(CELLS - 1)) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                    top_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = CLR_ALL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLR_ALL;
            col_q     <= '0;
            row_q     <= '0;
            top_q     <= '0;
            clr_row_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            top_q     <= top_d;
            clr_row_q <= clr_row_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        rd_oob  = (int'(term.rd_col) >= COLS) || (int'(term.rd_row) >= ROWS);
        rd_addr = rd_oob ? '0 : cell_addr(phys_row(top_q, term.rd_row), term.rd_col);
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data_q <= 8'h20;
        else rd_data_q <= rd_oob ? 8'h20 : mem[rd_addr];
    end
endmodule

// File: tb/tb_text_terminal.sv
// tb/tb_text_terminal.sv - randomized and directed bench for text_terminal in 80x30 and 8x4 configurations
module tb_text_terminal;
    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_a, rst_b;
    text_terminal_if #(.CW(7), .RW(5)) bus_a ();
    text_terminal_if #(.CW(3), .RW(2)) bus_b ();

    text_terminal #(.COLS(80), .ROWS(30), .TAB(8)) dut_a (.clk(clk), .reset(rst_a), .term(bus_a.slave));
    text_terminal #(.COLS(8), .ROWS(4), .TAB(4)) dut_b (.clk(clk), .reset(rst_b), .term(bus_b.slave));

    int    ncols [2] = '{80, 8};
    int    nrows [2] = '{30, 4};
    int    tabw  [2] = '{8, 4};
    int    cwb   [2] = '{7, 3};
    int    rwb   [2] = '{5, 2};
    string nm    [2] = '{"a", "b"};

    // Screen-relative model: a scroll physically moves rows up
    logic [7:0] scr [2][30][80];
    int mcol [2], mrow [2], busy_left [2], mode [2];
    int drv_rst [2], drv_valid [2], drv_data [2], drv_rcol [2], drv_rrow [2];
    int rd_mode [2], sweep_idx [2], accepted [2], exp_rd [2], exp_ok [2];
    int n_checks = 0;
    int n_fail = 0;

    function automatic int act_ready(int k);
        return (k == 0) ? int'(bus_a.in_ready) : int'(bus_b.in_ready);
    endfunction
    function automatic int act_busy(int k);
        return (k == 0) ? int'(bus_a.busy) : int'(bus_b.busy);
    endfunction
    function automatic int act_col(int k);
        return (k == 0) ? int'(bus_a.cur_col) : int'(bus_b.cur_col);
    endfunction
    function automatic int act_row(int k);
        return (k == 0) ? int'(bus_a.cur_row) : int'(bus_b.cur_row);
    endfunction
    function automatic int act_rd(int k);
        return (k == 0) ? int'(bus_a.rd_data) : int'(bus_b.rd_data);
    endfunction
    function automatic int model_ready(int k);
        return (drv_rst[k] == 0 && busy_left[k] == 0) ? 1 : 0;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic model_newline(int k);
        if (mrow[k] < nrows[k] - 1) begin
            mrow[k]++;
        end else begin
            for (int r = 0; r < nrows[k] - 1; r++)
                for (int c = 0; c < ncols[k]; c++) scr[k][r][c] = scr[k][r+1][c];
            for (int c = 0; c < ncols[k]; c++) scr[k][nrows[k]-1][c] = 8'h20;
            busy_left[k] = ncols[k];
            mode[k] = 1;
        end
    endtask

    task automatic model_edge(int k);
        int b;
        int rc = drv_rcol[k];
        int rr = drv_rrow[k];
        exp_ok[k] = 0;
        if (drv_rst[k] != 0 || rc >= ncols[k] || rr >= nrows[k]) begin
            exp_rd[k] = 8'h20;
            exp_ok[k] = 1;
        end else if (busy_left[k] == 0 || (mode[k] == 1 && rr != nrows[k] - 1)) begin
            exp_rd[k] = int'(scr[k][rr][rc]);
            exp_ok[k] = 1;
        end
        accepted[k] = 0;
        if (drv_rst[k] != 0) begin
            busy_left[k] = ncols[k] * nrows[k];
            mode[k] = 2;
            mcol[k] = 0;
            mrow[k] = 0;
        end else if (busy_left[k] > 0) begin
            busy_left[k]--;
            if (busy_left[k] == 0 && mode[k] == 2) begin
                for (int r = 0; r < nrows[k]; r++)
                    for (int c = 0; c < ncols[k]; c++) scr[k][r][c] = 8'h20;
                mcol[k] = 0;
                mrow[k] = 0;
            end
        end else if (drv_valid[k] != 0) begin
            accepted[k] = 1;
            b = drv_data[k];
            if (b >= 32 && b <= 126) begin
                scr[k][mrow[k]][mcol[k]] = 8'(b);
                if (mcol[k] == ncols[k] - 1) begin
                    mcol[k] = 0;
                    model_newline(k);
                end else begin
                    mcol[k]++;
                end
            end else begin
                case (b)
                    13: mcol[k] = 0;
                    10: model_newline(k);
                    8:  if (mcol[k] > 0) mcol[k]--;
                    9: begin
                        mcol[k] = (mcol[k] / tabw[k] + 1) * tabw[k];
                        if (mcol[k] > ncols[k] - 1) mcol[k] = ncols[k] - 1;
                    end
                    12: begin
                        busy_left[k] = ncols[k] * nrows[k];
                        mode[k] = 2;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic apply_inputs();
        rst_a          = (drv_rst[0] != 0);
        bus_a.in_valid = (drv_valid[0] != 0);
        bus_a.in_data  = 8'(drv_data[0]);
        bus_a.rd_col   = 7'(drv_rcol[0]);
        bus_a.rd_row   = 5'(drv_rrow[0]);
        rst_b          = (drv_rst[1] != 0);
        bus_b.in_valid = (drv_valid[1] != 0);
        bus_b.in_data  = 8'(drv_data[1]);
        bus_b.rd_col   = 3'(drv_rcol[1]);
        bus_b.rd_row   = 2'(drv_rrow[1]);
    endtask

    task automatic compare(int k);
        check({nm[k], "_in_ready"}, act_ready(k), model_ready(k));
        check({nm[k], "_busy"}, act_busy(k), 1 - model_ready(k));
        check({nm[k], "_cur_col"}, act_col(k), mcol[k]);
        check({nm[k], "_cur_row"}, act_row(k), mrow[k]);
        if (exp_ok[k] != 0) check({nm[k], "_rd_data"}, act_rd(k), exp_rd[k]);
    endtask

    task automatic choose_rd(int k);
        if (rd_mode[k] == 0) begin
            drv_rcol[k] = int'($urandom_range((1 << cwb[k]) - 1, 0));
            drv_rrow[k] = int'($urandom_range((1 << rwb[k]) - 1, 0));
        end else if (rd_mode[k] == 1) begin
            sweep_idx[k] = (sweep_idx[k] + 1) % (ncols[k] * nrows[k]);
            drv_rcol[k] = sweep_idx[k] % ncols[k];
            drv_rrow[k] = sweep_idx[k] / ncols[k];
        end
    endtask

    task automatic step();
        apply_inputs();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare(0);
        compare(1);
        choose_rd(0);
        choose_rd(1);
    endtask

    task automatic send(int k, int b);
        int n = 0;
        drv_valid[k] = 1;
        drv_data[k] = b;
        accepted[k] = 0;
        while (accepted[k] == 0 && n < 6000) begin
            step();
            n++;
        end
        drv_valid[k] = 0;
        check({nm[k], "_send_accepted"}, accepted[k], 1);
    endtask

    task automatic send_str(int k, string s);
        for (int i = 0; i < s.len(); i++) send(k, int'(s[i]));
    endtask

    task automatic wait_ready(input int k, output int n);
        n = 0;
        while (act_ready(k) == 0 && n < 5000) begin
            n++;
            step();
        end
    endtask

    task automatic peek(int k, int r, int c, int exp, string name);
        rd_mode[k] = 2;
        drv_rrow[k] = r;
        drv_rcol[k] = c;
        step();
        check(name, act_rd(k), exp);
        rd_mode[k] = 0;
    endtask

    task automatic sweep(int k);
        rd_mode[k] = 1;
        sweep_idx[k] = 0;
        drv_rcol[k] = 0;
        drv_rrow[k] = 0;
        repeat (ncols[k] * nrows[k]) step();
        rd_mode[k] = 0;
    endtask

    function automatic int pick_byte(int k);
        int r = int'($urandom_range(99, 0));
        if (r < 55) return int'($urandom_range(126, 32));
        if (r < 63) return 13;
        if (r < 73) return 10;
        if (r < 80) return 8;
        if (r < 88) return 9;
        if (r < 90 && k == 1) return 12;
        return int'($urandom_range(255, 0));
    endfunction

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            drv_rst[k] = 1; drv_valid[k] = 0; drv_data[k] = 0;
            drv_rcol[k] = 0; drv_rrow[k] = 0; rd_mode[k] = 0;
            mode[k] = 0; busy_left[k] = 0; mcol[k] = 0; mrow[k] = 0;
            accepted[k] = 0; exp_ok[k] = 0; exp_rd[k] = 0; sweep_idx[k] = 0;
        end
        repeat (3) step();
        drv_rst[0] = 0;
        drv_rst[1] = 0;
        apply_inputs();
        #1;
        wait_ready(0, n);
        check("a_reset_busy_cycles", n, 2400);
        check("a_reset_cur_col", act_col(0), 0);
        check("a_reset_cur_row", act_row(0), 0);
        sweep(0);
        peek(0, 29, 79, 8'h20, "a_last_cell");
        peek(0, 31, 127, 8'h20, "a_out_of_range");

        send_str(0, "AB");
        send(0, 8'h0D);
        send_str(0, "C");
        check("a_ready_after_text", act_ready(0), 1);
        check("a_col_after_text", act_col(0), 1);
        check("a_row_after_text", act_row(0), 0);
        peek(0, 0, 0, 8'h43, "a_cell_0_0");
        peek(0, 0, 1, 8'h42, "a_cell_0_1");

        send(0, 8'h0D);
        repeat (80) send(0, 8'h78);
        check("a_ready_after_80x", act_ready(0), 1);
        check("a_col_after_80x", act_col(0), 0);
        check("a_row_after_80x", act_row(0), 1);
        peek(0, 0, 79, 8'h78, "a_cell_0_79");

        send(0, 8'h08);
        check("a_bs_at_col0", act_col(0), 0);
        send_str(0, "abc");
        send(0, 8'h09);
        check("a_tab_from_3", act_col(0), 8);
        repeat (8) send(0, 8'h09);
        check("a_tab_chain", act_col(0), 72);
        send_str(0, "defghi");
        send(0, 8'h09);
        check("a_tab_from_78", act_col(0), 79);
        send(0, 8'h09);
        check("a_tab_from_79", act_col(0), 79);

        for (int i = 0; i < 4; i++) begin
            send(1, 8'h30 + i);
            send(1, 8'h0D);
            send(1, 8'h0A);
        end
        wait_ready(1, n);
        check("b_scroll_busy_cycles", n, 8);
        check("b_col_after_scroll", act_col(1), 0);
        check("b_row_after_scroll", act_row(1), 3);
        peek(1, 0, 0, 8'h31, "b_row0_after_scroll");
        peek(1, 1, 0, 8'h32, "b_row1_after_scroll");
        peek(1, 2, 0, 8'h33, "b_row2_after_scroll");
        peek(1, 3, 0, 8'h20, "b_row3_after_scroll");

        for (int i = 0; i < 5; i++) begin
            send(1, 8'h61 + i);
            send(1, 8'h0D);
            send(1, 8'h0A);
            wait_ready(1, n);
            check("b_wrap_scroll_busy_cycles", n, 8);
        end
        peek(1, 0, 0, 8'h63, "b_row0_after_wrap");
        peek(1, 1, 0, 8'h64, "b_row1_after_wrap");
        peek(1, 2, 0, 8'h65, "b_row2_after_wrap");
        peek(1, 3, 0, 8'h20, "b_row3_after_wrap");
        sweep(1);

        repeat (3000) begin
            for (int k = 0; k < 2; k++) begin
                drv_valid[k] = ($urandom_range(3, 0) != 0) ? 1 : 0;
                drv_data[k] = pick_byte(k);
            end
            drv_rst[1] = ($urandom_range(299, 0) == 0) ? 1 : 0;
            step();
        end
        drv_valid[0] = 0;
        drv_valid[1] = 0;
        drv_rst[1] = 0;
        n = 0;
        while ((act_ready(0) == 0 || act_ready(1) == 0) && n < 5000) begin
            step();
            n++;
        end
        check("a_ready_after_random", act_ready(0), 1);
        check("b_ready_after_random", act_ready(1), 1);
        sweep(0);
        sweep(1);

        send_str(0, "hi");
        send(0, 8'h0C);
        wait_ready(0, n);
        check("a_ff_busy_cycles", n, 2400);
        check("a_ff_cur_col", act_col(0), 0);
        check("a_ff_cur_row", act_row(0), 0);
        sweep(0);
        peek(0, 0, 0, 8'h20, "a_ff_cell_0_0");
        send(0, 8'h07);
        check("a_bel_ready", act_ready(0), 1);
        check("a_bel_cur_col", act_col(0), 0);
        check("a_bel_cur_row", act_row(0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
